bg_scroll_renderer: RTL

- Parametrised background renderer for the 640x480 VGA path.
- Maps each screen pixel (DrawX, DrawY) to a source-image texel using integer pixel replication and a per-frame scroll offset with wrap-around.
- Issues the texel address to an external synchronous background ROM, resolves the returned index through an external palette, and drives registered 4-bit RGB.
- Replaces divide-based address generation with incremental counters, so the source image no longer has to match the screen size.

---
 rtl/bg_scroll_renderer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bg_scroll_renderer.sv
// bg_scroll_renderer
//   Background layer for the 640x480 VGA path. Each screen pixel (DrawX, DrawY)
//   is mapped to a source texel using integer replication (X_SCALE, Y_SCALE)
//   and a per-frame scroll offset that wraps around the source image. The texel
//   address goes to an external synchronous ROM, the returned index goes out to
//   an external palette, and the palette colour is registered onto red/green/blue.
//
// Ports
//   vga_clk                    pixel clock
//   Reset                      synchronous active-high reset
//   DrawX, DrawY               current screen coordinate
//   blank                      1 = visible pixel, 0 = blanking
//   scroll_x, scroll_y         texel scroll offsets, latched at frame start
//   rom_address                registered texel address to the background ROM
//   rom_q                      ROM data, ROM_LAT cycles after rom_address
//   pal_index                  rom_q passed straight through to the palette
//   pal_red/green/blue         palette colour for pal_index
//   red, green, blue           registered pixel colour
module bg_scroll_renderer #(
    parameter int unsigned SRC_W   = 320,
    parameter int unsigned SRC_H   = 240,
    parameter int unsigned X_SCALE = 2,
    parameter int unsigned Y_SCALE = 2,
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic                       vga_clk,
    input  logic                       Reset,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic                       blank,
    input  logic [$clog2(SRC_W)-1:0]   scroll_x,
    input  logic [$clog2(SRC_H)-1:0]   scroll_y,
    output logic [ADDR_W-1:0]          rom_address,
    input  logic [IDX_W-1:0]           rom_q,
    output logic [IDX_W-1:0]           pal_index,
    input  logic [3:0]                 pal_red,
    input  logic [3:0]                 pal_green,
    input  logic [3:0]                 pal_blue,
    output logic [3:0]                 red,
    output logic [3:0]                 green,
    output logic [3:0]                 blue
);

    localparam int unsigned SXW = $clog2(SRC_W);
    localparam int unsigned SYW = $clog2(SRC_H);
    localparam int unsigned XRW = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
    localparam int unsigned YRW = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;

    localparam logic [SXW:0]        LP_SRC_W    = (SXW+1)'(SRC_W);
    localparam logic [SYW:0]        LP_SRC_H    = (SYW+1)'(SRC_H);
    localparam logic [SXW-1:0]      LP_SX_LAST  = SXW'(SRC_W - 1);
    localparam logic [SYW-1:0]      LP_SY_LAST  = SYW'(SRC_H - 1);
    localparam logic [XRW-1:0]      LP_XR_LAST  = XRW'(X_SCALE - 1);
    localparam logic [YRW-1:0]      LP_YR_LAST  = YRW'(Y_SCALE - 1);
    localparam logic [ADDR_W-1:0]   LP_ROW_STEP = ADDR_W'(SRC_W);
    localparam logic [9:0]          LP_VIS_W    = 10'd640;
    localparam logic [9:0]          LP_VIS_H    = 10'd480;

    logic [SXW-1:0]     r_sx_base, r_sx_cur;
    logic [XRW-1:0]     r_x_rep;
    logic [SYW-1:0]     r_sy_cur;
    logic [YRW-1:0]     r_y_rep;
    logic [ADDR_W-1:0]  r_row_base, r_addr;
    logic [9:0]         r_prev_x, r_prev_y;
    logic               r_armed;
    logic [ROM_LAT:0]   r_blank_pipe;
    logic [3:0]         r_red, r_green, r_blue;

    logic               w_frame_start, w_line_start, w_visible;
    logic               w_h_step, w_v_step, w_blank_in;
    logic [SXW-1:0]     w_sx_lat, w_sx_base_nxt, w_sx_nxt;
    logic [SYW-1:0]     w_sy_lat, w_sy_nxt;
    logic [XRW-1:0]     w_xrep_nxt;
    logic [YRW-1:0]     w_yrep_nxt;
    logic [ADDR_W-1:0]  w_row_nxt, w_addr_nxt;

    // Counters are computed for the current sample so that the registered
    // address already belongs to this DrawX/DrawY (stage A).
    always_comb begin
        w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
        w_line_start  = (DrawX == 10'd0);
        w_visible     = (DrawX < LP_VIS_W) && (DrawY < LP_VIS_H);
        w_h_step      = w_visible && !w_line_start && (DrawX == r_prev_x + 10'd1);
        w_v_step      = w_line_start && (DrawY < LP_VIS_H) && (DrawY == r_prev_y + 10'd1);

        w_sx_lat = ({1'b0, scroll_x} >= LP_SRC_W) ? '0 : scroll_x;
        w_sy_lat = ({1'b0, scroll_y} >= LP_SRC_H) ? '0 : scroll_y;

        w_sx_base_nxt = r_sx_base;
        w_sy_nxt      = r_sy_cur;
        w_yrep_nxt    = r_y_rep;
        w_row_nxt     = r_row_base;
        if (w_frame_start) begin
            w_sx_base_nxt = w_sx_lat;
            w_sy_nxt      = w_sy_lat;
            w_yrep_nxt    = '0;
            // Constant-coefficient product, evaluated only on the frame-start
            // cycle; every later row uses the +SRC_W accumulator.
            w_row_nxt     = ADDR_W'(w_sy_lat) * LP_ROW_STEP;
        end else if (w_v_step) begin
            if (r_y_rep == LP_YR_LAST) begin
                w_yrep_nxt = '0;
                if (r_sy_cur == LP_SY_LAST) begin
                    w_sy_nxt  = '0;
                    w_row_nxt = '0;
                end else begin
                    w_sy_nxt  = r_sy_cur + 1'b1;
                    w_row_nxt = r_row_base + LP_ROW_STEP;
                end
            end else begin
                w_yrep_nxt = r_y_rep + 1'b1;
            end
        end

        w_sx_nxt   = r_sx_cur;
        w_xrep_nxt = r_x_rep;
        if (w_line_start) begin
            w_sx_nxt   = w_sx_base_nxt;
            w_xrep_nxt = '0;
        end else if (w_h_step) begin
            if (r_x_rep == LP_XR_LAST) begin
                w_xrep_nxt = '0;
                w_sx_nxt   = (r_sx_cur == LP_SX_LAST) ? '0 : r_sx_cur + 1'b1;
            end else begin
                w_xrep_nxt = r_x_rep + 1'b1;
            end
        end

        w_addr_nxt = w_row_nxt + ADDR_W'(w_sx_nxt);
        // After reset nothing is drawn until a frame start re-establishes the counters.
        w_blank_in = blank && (r_armed || w_frame_start);
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_sx_base    <= '0;
            r_sx_cur     <= '0;
            r_x_rep      <= '0;
            r_sy_cur     <= '0;
            r_y_rep      <= '0;
            r_row_base   <= '0;
            r_addr       <= '0;
            r_prev_x     <= '0;
            r_prev_y     <= '0;
            r_armed      <= 1'b0;
            r_blank_pipe <= '0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
        end else begin
            r_sx_base    <= w_sx_base_nxt;
            r_sx_cur     <= w_sx_nxt;
            r_x_rep      <= w_xrep_nxt;
            r_sy_cur     <= w_sy_nxt;
            r_y_rep      <= w_yrep_nxt;
            r_row_base   <= w_row_nxt;
            r_prev_x     <= DrawX;
            r_prev_y     <= DrawY;
            r_armed      <= r_armed || w_frame_start;
            if (w_visible) begin
                r_addr <= w_addr_nxt;
            end
            r_blank_pipe <= {r_blank_pipe[ROM_LAT-1:0], w_blank_in};
            if (r_blank_pipe[ROM_LAT]) begin
                r_red   <= pal_red;
                r_green <= pal_green;
                r_blue  <= pal_blue;
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
        end
    end

    assign rom_address = r_addr;
    assign pal_index   = rom_q;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;

endmodule
